// File: rtl/gate_equiv_sweeper.sv
// rtl/gate_equiv_sweeper.sv - exhaustive truth-table sweeper comparing two combinational implementations
// Optional macro STOP_ON_FAIL_EN: end the sweep at the first mismatching minterm.
module gate_equiv_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            res_a,
  input  logic            res_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail,
  output logic [N_IN:0]   mismatch_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t          r_state,  w_state_nxt;
  logic [3:0]      r_cnt,    w_cnt_nxt;
  logic [N_IN-1:0] r_stim,   w_stim_nxt;
  logic [N_IN-1:0] r_ff,     w_ff_nxt;
  logic [N_IN:0]   r_mcnt,   w_mcnt_nxt;
  logic            r_busy,   w_busy_nxt;
  logic            r_done,   w_done_nxt;
  logic            r_pass,   w_pass_nxt;
  logic            r_fs,     w_fs_nxt;
  logic            w_mismatch;
  logic            w_last;
  logic            w_stop;

  assign w_mismatch = res_a ^ res_b;
  assign w_last     = &r_stim;

`ifdef STOP_ON_FAIL_EN
  assign w_stop = w_last | w_mismatch;
`else
  assign w_stop = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stim  <= '0;
      r_ff    <= '0;
      r_mcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stim  <= w_stim_nxt;
      r_ff    <= w_ff_nxt;
      r_mcnt  <= w_mcnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_fs    <= w_fs_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stim_nxt  = r_stim;
    w_ff_nxt    = r_ff;
    w_mcnt_nxt  = r_mcnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_fs_nxt    = r_fs;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = SETTLE_C;
          w_stim_nxt  = '0;
          w_ff_nxt    = '0;
          w_mcnt_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_pass_nxt  = 1'b0;
          w_fs_nxt    = 1'b0;
        end
      end
      RUN: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          if (w_mismatch) begin
            w_mcnt_nxt = r_mcnt + (N_IN+1)'(1);
            if (!r_fs) begin
              w_ff_nxt = r_stim;
              w_fs_nxt = 1'b1;
            end
          end
          // pass must account for the compare happening on this same edge
          if (w_stop) begin
            w_state_nxt = DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = ~(r_fs | w_mismatch);
          end else begin
            w_stim_nxt = r_stim + N_IN'(1);
            w_cnt_nxt  = SETTLE_C;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign stim         = r_stim;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign fail_seen    = r_fs;
  assign first_fail   = r_ff;
  assign mismatch_cnt = r_mcnt;

endmodule

// File: tb/tb_gate_equiv_sweeper.sv
// tb/tb_gate_equiv_sweeper.sv - scoreboard bench for gate_equiv_sweeper at SETTLE=0 and SETTLE=1
module tb_gate_equiv_sweeper;

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  typedef struct {
    int t;
    int mc;
    int ff;
    bit fs;
    bit pass;
    int stim;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [1:0] stim0, stim1, ff0, ff1;
  logic [2:0] mc0, mc1;
  logic       res_a0, res_b0, res_a1, res_b1;
  logic       busy0, done0, pass0, fs0;
  logic       busy1, done1, pass1, fs1;
  int         mode = 0;
  logic       sel = 1'b0;

  logic [1:0] o_stim, o_ff;
  logic [2:0] o_mc;
  logic       o_busy, o_done, o_pass, o_fs;

  exp_t sb[$];
  int   stim_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // mode 0: A=a'b, B=a^b; mode 1: both a'b; mode 2: A=ab, B=~(ab)
  function automatic logic f_a(input int m, input logic [1:0] s);
    if (m == 2) return s[1] & s[0];
    return ~s[1] & s[0];
  endfunction

  function automatic logic f_b(input int m, input logic [1:0] s);
    if (m == 0) return s[1] ^ s[0];
    if (m == 1) return ~s[1] & s[0];
    return ~(s[1] & s[0]);
  endfunction

  assign res_a0 = f_a(mode, stim0);
  assign res_b0 = f_b(mode, stim0);
  assign res_a1 = f_a(mode, stim1);
  assign res_b1 = f_b(mode, stim1);

  assign o_stim = sel ? stim1 : stim0;
  assign o_ff   = sel ? ff1   : ff0;
  assign o_mc   = sel ? mc1   : mc0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_pass = sel ? pass1 : pass0;
  assign o_fs   = sel ? fs1   : fs0;

  gate_equiv_sweeper #(.N_IN(2), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim(stim0),
    .res_a(res_a0), .res_b(res_b0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_seen(fs0), .first_fail(ff0), .mismatch_cnt(mc0)
  );

  gate_equiv_sweeper #(.N_IN(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stim(stim1),
    .res_a(res_a1), .res_b(res_b1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_seen(fs1), .first_fail(ff1), .mismatch_cnt(mc1)
  );

  task automatic push_model(input int m, input int settle);
    exp_t e;
    logic [1:0] s;
    int last;
    bit mis;
    e.mc = 0; e.ff = 0; e.fs = 0;
    last = 3;
    for (int i = 0; i < 4; i++) begin
      s = i[1:0];
      mis = f_a(m, s) ^ f_b(m, s);
      if (mis) begin
        e.mc++;
        if (!e.fs) begin
          e.ff = i;
          e.fs = 1'b1;
        end
      end
      if (STOP_EN && mis) begin
        last = i;
        break;
      end
    end
    e.t    = (last + 1) * (settle + 1);
    e.pass = !e.fs;
    e.stim = last;
    stim_q.delete();
    for (int c = 0; c < e.t; c++) stim_q.push_back(c / (settle + 1));
    sb.push_back(e);
  endtask

  task automatic run_sweep(input bit s, input int m, input int poke);
    exp_t e;
    int   c;
    int   exp_s;
    bit   got;
    sel  = s;
    mode = m;
    push_model(m, s ? 1 : 0);
    @(negedge clk);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    c = 0; got = 1'b0;
    while (c < 200 && !got) begin
      if (c == poke) begin
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      if (c == poke + 1) begin
        start0 = 1'b0; start1 = 1'b0;
      end
      if (o_done) begin
        got = 1'b1;
        e = sb.pop_front();
        n_tests++;
        if (c !== e.t) begin n_fail++; $display("FAIL done_latency mode=%0d got=%0d exp=%0d", m, c, e.t); end
        n_tests++;
        if (o_mc !== 3'(e.mc)) begin n_fail++; $display("FAIL mismatch_cnt mode=%0d got=%0d exp=%0d", m, o_mc, e.mc); end
        n_tests++;
        if (o_ff !== 2'(e.ff)) begin n_fail++; $display("FAIL first_fail mode=%0d got=%0d exp=%0d", m, o_ff, e.ff); end
        n_tests++;
        if (o_fs !== e.fs) begin n_fail++; $display("FAIL fail_seen mode=%0d got=%0b exp=%0b", m, o_fs, e.fs); end
        n_tests++;
        if (o_pass !== e.pass) begin n_fail++; $display("FAIL pass mode=%0d got=%0b exp=%0b", m, o_pass, e.pass); end
        n_tests++;
        if (o_stim !== 2'(e.stim)) begin n_fail++; $display("FAIL final_stim mode=%0d got=%0d exp=%0d", m, o_stim, e.stim); end
        n_tests++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done mode=%0d got=%0b exp=0", m, o_busy); end
      end else begin
        exp_s = (stim_q.size() > 0) ? stim_q.pop_front() : -1;
        n_tests++;
        if (o_stim !== 2'(exp_s) || exp_s < 0) begin
          n_fail++; $display("FAIL stim_step mode=%0d cycle=%0d got=%0d exp=%0d", m, c, o_stim, exp_s);
        end
        n_tests++;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_run mode=%0d cycle=%0d got=%0b exp=1", m, c, o_busy); end
      end
      if (!got) begin
        @(negedge clk);
        c++;
      end
    end
    start0 = 1'b0; start1 = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout mode=%0d got=none exp=done", m);
      void'(sb.pop_front());
    end else begin
      @(negedge clk);
      n_tests++;
      if (o_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width mode=%0d got=%0b exp=0", m, o_done); end
      n_tests++;
      if (o_mc !== 3'(e.mc) || o_pass !== e.pass) begin
        n_fail++; $display("FAIL results_hold mode=%0d got=%0d/%0b exp=%0d/%0b", m, o_mc, o_pass, e.mc, e.pass);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({stim0, busy0, done0, pass0, fs0, ff0, mc0} !== '0) begin
      n_fail++; $display("FAIL reset_dut0 got=%b exp=0", {stim0, busy0, done0, pass0, fs0, ff0, mc0});
    end
    n_tests++;
    if ({stim1, busy1, done1, pass1, fs1, ff1, mc1} !== '0) begin
      n_fail++; $display("FAIL reset_dut1 got=%b exp=0", {stim1, busy1, done1, pass1, fs1, ff1, mc1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_restart;
    run_sweep(1'b1, 0, 2);
    run_sweep(1'b1, 1, -10);
  endtask

  task automatic test_reset_mid;
    int  c;
    bit  saw_done;
    sel  = 1'b1;
    mode = STOP_EN ? 1 : 2;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    c = 0;
    while (stim1 !== 2'd2 && c < 50) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (stim1 !== 2'd2) begin n_fail++; $display("FAIL reach_stim2 got=%0d exp=2", stim1); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (stim1 !== 2'd0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_stim_busy got=%0d/%0b exp=0/0", stim1, busy1);
    end
    n_tests++;
    if (mc1 !== 3'd0 || fs1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_results got=%0d/%0b/%0b exp=0/0/0", mc1, fs1, done1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done1 || busy1) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin n_fail++; $display("FAIL no_done_after_reset got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    run_sweep(1'b1, 0, -10);
    run_sweep(1'b0, 1, -10);
    run_sweep(1'b0, 2, -10);
    test_busy_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
